regfile_reader: RTL and testbench

- Read-side sequencer for the 16x16 register file: the counterpart to its write port.
- On a start command it walks a range of register addresses and drives both asynchronous read ports, two registers per fetch.
- It captures each pair and streams the words out one at a time on a valid/ready interface, tagged with address and last flag.
- Used for register dumps, debug readout and bulk operand transfer.

---
 rtl/regfile_reader_pkg.sv | 21 ++
 rtl/regfile_out_stage.sv | 39 +++
 rtl/regfile_reader.sv | 111 +++++++++++
 tb/tb_regfile_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared constants and types for the register file and its read-side sequencer.
package regfile_reader_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_A,
        SEND_B,
        DONE
    } state_t;

    // Requested word count limited to one full pass over the register file.
    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
        return (c > (ADDR_W + 1)'(DEPTH)) ? (ADDR_W + 1)'(DEPTH) : c;
    endfunction

endpackage

// File: rtl/regfile_out_stage.sv
// Two-word holding register filled by one fetch, plus the mux that presents
// either word (and its address) on the streaming output.
module regfile_out_stage
    import regfile_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              sel_b,
    input  logic [ADDR_W-1:0] ptr,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DATA_W-1:0] word1;
    logic [DATA_W-1:0] word2;

    // Snapshot both read ports at the end of the fetch cycle.
    // NOTE: the holding words are reset as well so out_data is a defined 0 out of
    // reset; all sequential state here uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word1 <= '0;
            word2 <= '0;
        end else if (capture) begin
            word1 <= rd_data1;
            word2 <= rd_data2;
        end
    end

    // Present the first or second word of the pair with its source address.
    always_comb begin
        out_data = sel_b ? word2 : word1;
        out_addr = sel_b ? ptr + ADDR_W'(1) : ptr;
    end

endmodule

// File: rtl/regfile_reader.sv
// Read-side sequencer: walks an address range two registers per fetch and
// streams the words out on a valid/ready interface with address and last tag.
module regfile_reader
    import regfile_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] REM_TWO = (ADDR_W + 1)'(2);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W:0]   rem;
    logic [ADDR_W:0]   rem_next;
    logic              capture;
    logic              sel_b;

    // State, range pointer and read-port addresses; the read addresses are
    // loaded on entry to FETCH so they are already valid during that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            rem   <= rem_next;
            if (state_next == FETCH) begin
                rd_addr1 <= ptr_next;
                rd_addr2 <= ptr_next + ADDR_W'(1);
            end
        end
    end

    // Next state, pointer and remaining-word count.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        rem_next   = rem;
        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    ptr_next   = base_addr;
                    rem_next   = clamp_count(count);
                    state_next = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_next = SEND_A;
            SEND_A: begin
                if (out_ready) begin
                    rem_next   = rem - REM_ONE;
                    state_next = (rem >= REM_TWO) ? SEND_B : DONE;
                end
            end
            SEND_B: begin
                if (out_ready) begin
                    rem_next   = rem - REM_ONE;
                    ptr_next   = ptr + ADDR_W'(2);
                    state_next = (rem >= REM_TWO) ? FETCH : DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status and handshake outputs decoded from the current state.
    always_comb begin
        busy      = (state == FETCH) || (state == SEND_A) || (state == SEND_B);
        done      = (state == DONE);
        out_valid = (state == SEND_A) || (state == SEND_B);
        out_last  = out_valid && (rem == REM_ONE);
        capture   = (state == FETCH);
        sel_b     = (state == SEND_B);
    end

    regfile_out_stage u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .sel_b    (sel_b),
        .ptr      (ptr),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .out_data (out_data),
        .out_addr (out_addr)
    );

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: a behavioural register file, a queue-based model of
// the expected word stream, table-driven readouts, hand sequences for write
// coherence and mid-readout reset, and randomized readouts.
module tb_regfile_reader;
    import regfile_reader_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    // Behavioural register file: synchronous write, asynchronous read.
    logic [DATA_W-1:0] rf [DEPTH];
    logic              we = 1'b0;
    logic [ADDR_W-1:0] wa = '0;
    logic [DATA_W-1:0] wd = '0;

    always #5 clk = ~clk;

    always @(posedge clk) if (we) rf[wa] <= wd;

    assign rd_data1 = rf[rd_addr1];
    assign rd_data2 = rf[rd_addr2];

    regfile_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    typedef struct {
        int                setup;       // 1: load the wrap-test data first
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   cnt;
        int                ready_pct;
        int                stall;       // ready held low this many valid cycles first
        int                exp_words;
        int                exp_cycles;  // cycle index where done is seen; 0 = unchecked
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rf_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // One readout: the expected stream is min(count,16) consecutive addresses
    // (mod 16) carrying the register contents at start time, last on the final one.
    task automatic run_readout(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c,
                               input int ready_pct, input int stall,
                               output int words, output int done_cyc);
        word_t             exp_q[$];
        word_t             w;
        logic [ADDR_W-1:0] a2;
        int                n;
        int                cyc;
        int                stall_left;
        int                last_hs;
        bit                got_done;
        bit                first_seen;

        n = (c > 16) ? 16 : int'(c);
        for (int i = 0; i < n; i++) begin
            w.addr = ADDR_W'(int'(b) + i);
            w.data = rf[w.addr];
            w.last = (i == n - 1);
            exp_q.push_back(w);
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 1;
        words      = 0;
        got_done   = 1'b0;
        first_seen = 1'b0;
        last_hs    = -1;
        stall_left = stall;

        while (cyc <= 300) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    check("first_valid_latency", cyc, 2);
                end
                if (exp_q.size() == 0) begin
                    check("extra_word_valid", out_valid, 1'b0);
                    out_ready = 1'b1;
                end else begin
                    check("word_addr", out_addr, exp_q[0].addr);
                    check("word_data", out_data, exp_q[0].data);
                    check("word_last", out_last, exp_q[0].last);
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = ($urandom_range(0, 99) < ready_pct);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        words++;
                        last_hs = cyc;
                    end
                end
            end else begin
                if (busy && exp_q.size() > 0) begin
                    a2 = exp_q[0].addr + ADDR_W'(1);
                    check("fetch_rd_addr1", rd_addr1, exp_q[0].addr);
                    check("fetch_rd_addr2", rd_addr2, a2);
                end
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end

        out_ready = 1'b0;
        check("done_seen", got_done, 1'b1);
        done_cyc = -1;
        if (got_done) begin
            done_cyc = cyc;
            if (n > 0) check("done_after_last", cyc - last_hs, 1);
            check("words_left", exp_q.size(), 0);
            check("busy_in_done", busy, 1'b0);
            check("valid_in_done", out_valid, 1'b0);
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   words;
        int   done_cyc;
        int   exp_n;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W:0]   rc;

        // Reset state.
        #1 rst = 1'b0;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_addr1", rd_addr1, 4'd0);
        check("rst_rd_addr2", rd_addr2, 4'd0);
        check("rst_out_addr", out_addr, 4'd0);
        check("rst_out_data", out_data, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) rf_write(ADDR_W'(i), DATA_W'(16'h0F00 + i * 16'h0101));
        rf_write(4'd0, 16'h1111);
        rf_write(4'd1, 16'h2222);
        rf_write(4'd2, 16'h3333);
        rf_write(4'd3, 16'h4444);

        //               setup base  cnt    pct stall words cycles
        vecs.push_back('{0, 4'd0,  5'd4,  100, 0, 4,  7});   // basic four-word dump
        vecs.push_back('{1, 4'd15, 5'd3,  100, 0, 3,  6});   // wrap 15->0, odd count
        vecs.push_back('{0, 4'd5,  5'd2,  100, 5, 2,  9});   // backpressure
        vecs.push_back('{0, 4'd3,  5'd0,  100, 0, 0,  1});   // count 0: done only
        vecs.push_back('{0, 4'd9,  5'd20, 100, 0, 16, 25});  // clamp to 16
        vecs.push_back('{0, 4'd7,  5'd16, 100, 0, 16, 25});  // full pass from mid base
        vecs.push_back('{0, 4'd6,  5'd1,  100, 0, 1,  3});   // single word
        vecs.push_back('{0, 4'd14, 5'd5,  50,  1, 5,  0});   // random ready, wrap

        foreach (vecs[i]) begin
            if (vecs[i].setup == 1) begin
                rf_write(4'd15, 16'hAAAA);
                rf_write(4'd0, 16'hBBBB);
                rf_write(4'd1, 16'hCCCC);
            end
            run_readout(vecs[i].base, vecs[i].cnt, vecs[i].ready_pct, vecs[i].stall, words, done_cyc);
            check("vec_words", words, vecs[i].exp_words);
            if (vecs[i].exp_cycles > 0) check("vec_done_cycle", done_cyc, vecs[i].exp_cycles);
        end

        // Write coherence: a write on the capture edge and one after it are both invisible.
        rf_write(4'd2, 16'h5555);
        rf_write(4'd3, 16'h3333);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 4'd2;
        count     = 5'd2;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("wc_fetch_addr", rd_addr1, 4'd2);
        we = 1'b1;
        wa = 4'd2;
        wd = 16'h9999;
        @(negedge clk);
        we = 1'b0;
        check("wc_valid", out_valid, 1'b1);
        check("wc_same_edge", out_data, 16'h5555);
        we = 1'b1;
        wd = 16'h7777;
        @(negedge clk);
        we = 1'b0;
        check("wc_after_capture", out_data, 16'h5555);
        out_ready = 1'b1;
        @(negedge clk);
        check("wc_b_data", out_data, 16'h3333);
        check("wc_b_addr", out_addr, 4'd3);
        check("wc_b_last", out_last, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        check("wc_done", done, 1'b1);
        @(negedge clk);

        // Reset during SEND_B with the consumer stalled.
        start     = 1'b1;
        base_addr = 4'd8;
        count     = 5'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rst_mid_pre_valid", out_valid, 1'b1);
        check("rst_mid_pre_addr", out_addr, 4'd9);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_no_done", done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", busy, 1'b0);
        run_readout(4'd12, 5'd2, 100, 0, words, done_cyc);
        check("rst_mid_restart_words", words, 2);

        // Randomized readouts against the queue model.
        for (int r = 0; r < 24; r++) begin
            rf_write(ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            rf_write(ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            rb    = ADDR_W'($urandom_range(0, 15));
            rc    = (ADDR_W + 1)'($urandom_range(0, 20));
            exp_n = (rc > 16) ? 16 : int'(rc);
            run_readout(rb, rc, $urandom_range(30, 100), $urandom_range(0, 3), words, done_cyc);
            check("rand_words", words, exp_n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
